// File: rtl/shift_tx_arb.sv
// Two-requester round-robin arbiter feeding a WIDTH-bit parallel-to-serial shifter.
// Frames go out MSB first. A downstream hold freezes the frame in place.
module shift_tx_arb #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    input  logic             ser_hold,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             grant_id,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             gid_q, gid_d;
    logic             ser_last_q, ser_last_d;
    logic             gnt;
    logic             accept;

    // On a tie, grant goes to the requester that was not served last.
    always_comb begin
        gnt = 1'b0;
        if (req0_valid && req1_valid) gnt = ~last_q;
        else if (req1_valid)          gnt = 1'b1;
    end

    assign req0_ready = (state_q == IDLE) && !gnt && req0_valid && rst;
    assign req1_ready = (state_q == IDLE) &&  gnt && req1_valid && rst;
    assign accept     = req0_ready | req1_ready;

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        gid_d      = gid_q;
        ser_last_d = ser_last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d     = gnt ? req1_data : req0_data;
                    gid_d      = gnt;
                    last_d     = gnt;
                    cnt_d      = '0;
                    ser_last_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (!ser_hold) begin
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    if (cnt_q == LAST_CNT) begin
                        cnt_d      = '0;
                        ser_last_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d      = cnt_q + CW'(1);
                        ser_last_d = ((cnt_q + CW'(1)) == LAST_CNT);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            gid_q      <= 1'b0;
            ser_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            gid_q      <= gid_d;
            ser_last_q <= ser_last_d;
        end
    end

    // The register is fully shifted out by the end of a frame, so ser_out idles at 0.
    assign ser_out   = sreg_q[WIDTH-1];
    assign ser_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign ser_last  = ser_last_q;
    assign grant_id  = gid_q;

endmodule

// File: tb/tb_shift_tx_arb.sv
// Testbench for shift_tx_arb: vector table, directed corner sequences, then
// randomized traffic checked against a frame-level reference model.
module tb_shift_tx_arb;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0, ser_hold = 1'b0;
    logic [W-1:0] req0_data = '0, req1_data = '0;
    logic         req0_ready, req1_ready, ser_out, ser_valid, ser_last, grant_id, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_tx_arb #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .ser_hold   (ser_hold),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    typedef struct {
        logic         rst;
        logic         v0;
        logic [W-1:0] d0;
        logic         v1;
        logic [W-1:0] d1;
        logic         hold;
        logic [6:0]   exp;  // {r0, r1, ser_out, ser_valid, ser_last, grant_id, busy}
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {req0_ready, req1_ready, ser_out, ser_valid, ser_last, grant_id, busy};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; ser_hold = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Captures W consecutive cycles, first-seen cycle in the MSB.
    task automatic grab(output logic [W-1:0] bits, output logic [W-1:0] lasts,
                        output logic [W-1:0] valids, output logic [W-1:0] readys,
                        output logic [W-1:0] gids);
        bits = '0; lasts = '0; valids = '0; readys = '0; gids = '0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            #1;
            bits   = {bits[W-2:0], ser_out};
            lasts  = {lasts[W-2:0], ser_last};
            valids = {valids[W-2:0], ser_valid};
            readys = {readys[W-2:0], req0_ready | req1_ready};
            gids   = {gids[W-2:0], grant_id};
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t         tbl [7];
        logic [4:0]   tie_exp [15];
        logic [4:0]   stall_exp [10];
        logic [W-1:0] bits, lasts, valids, readys, gids;
        logic         m_busy, m_gid, m_last, acc0, acc1, g, e_r0, e_r1, e_so, e_sl;
        logic [W-1:0] m_word;
        logic [6:0]   exp;
        int           m_pos;

        // Single frame 1011 from requester 0 straight out of reset.
        tbl[0] = '{1'b0, 1'b1, 4'b1011, 1'b0, 4'h0, 1'b0, 7'b0000000};
        tbl[1] = '{1'b1, 1'b1, 4'b1011, 1'b0, 4'h0, 1'b0, 7'b1000000};
        tbl[2] = '{1'b1, 1'b0, 4'h0,    1'b0, 4'h0, 1'b0, 7'b0011001};
        tbl[3] = '{1'b1, 1'b0, 4'h0,    1'b0, 4'h0, 1'b0, 7'b0001001};
        tbl[4] = '{1'b1, 1'b0, 4'h0,    1'b0, 4'h0, 1'b0, 7'b0011001};
        tbl[5] = '{1'b1, 1'b0, 4'h0,    1'b0, 4'h0, 1'b0, 7'b0011101};
        tbl[6] = '{1'b1, 1'b0, 4'h0,    1'b0, 4'h0, 1'b0, 7'b0000000};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; req0_valid = tbl[i].v0; req0_data = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_data = tbl[i].d1; ser_hold = tbl[i].hold;
            #1;
            check($sformatf("single vec%0d", i), 8'(outs()), 8'(tbl[i].exp));
        end

        // Tie: {r0, r1, ser_valid, ser_out, grant_id} per cycle.
        tie_exp = '{5'b10000, 5'b00110, 5'b00110, 5'b00110, 5'b00110,
                    5'b01000, 5'b00101, 5'b00101, 5'b00101, 5'b00111,
                    5'b10001, 5'b00110, 5'b00110, 5'b00110, 5'b00110};
        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req0_valid = 1'b1; req0_data = 4'b1111;
                req1_valid = 1'b1; req1_data = 4'b0001;
            end
            #1;
            check($sformatf("tie cyc%0d", i),
                  8'({req0_ready, req1_ready, ser_valid, ser_out, grant_id}), 8'(tie_exp[i]));
        end

        // Stall on the second bit: {r1, ser_valid, ser_out, ser_last, grant_id}.
        stall_exp = '{5'b10000, 5'b01101, 5'b01001, 5'b01001, 5'b01001,
                      5'b01001, 5'b01001, 5'b01011, 5'b00001, 5'b00001};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin req1_valid = 1'b1; req1_data = 4'b1000; end
            if (i == 1) req1_valid = 1'b0;
            ser_hold = (i >= 2 && i <= 4);
            #1;
            check($sformatf("stall cyc%0d", i),
                  8'({req1_ready, ser_valid, ser_out, ser_last, grant_id}), 8'(stall_exp[i]));
        end

        // Reset in the middle of a frame, then a fresh frame.
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 4'b0101;
        #1 check("mrst accept", 8'(req0_ready), 8'(1));
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        #1 check("mrst bit0", 8'({ser_valid, ser_out}), 8'(2'b10));
        @(negedge clk);
        #1 check("mrst bit1", 8'({ser_valid, ser_out}), 8'(2'b11));
        @(negedge clk);
        #2 rst = 1'b0;
        req0_valid = 1'b1; req0_data = 4'b0011;
        #1 check("mrst async drop", 8'({ser_valid, busy, ser_last, req0_ready}), 8'(0));
        @(negedge clk);
        rst = 1'b1;
        #1 check("mrst re-arb", 8'({req0_ready, ser_valid, grant_id}), 8'(3'b100));
        @(posedge clk);
        #1 req0_valid = 1'b0;
        grab(bits, lasts, valids, readys, gids);
        check("mrst frame bits", 8'(bits), 8'(4'b0011));
        check("mrst frame last", 8'(lasts), 8'(4'b0001));
        check("mrst frame valid", 8'(valids), 8'(4'b1111));
        check("mrst frame gid", 8'(gids), 8'(4'b0000));

        // Data changed during SHIFT must not leak into the current frame.
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 4'b1100;
        #1 check("busy accept", 8'(req0_ready), 8'(1));
        @(posedge clk);
        #1 req0_data = 4'b0011;
        grab(bits, lasts, valids, readys, gids);
        check("busy frame bits", 8'(bits), 8'(4'b1100));
        check("busy no ready", 8'(readys), 8'(0));
        check("busy frame last", 8'(lasts), 8'(4'b0001));
        @(negedge clk);
        #1 check("busy idle gap", 8'({req0_ready, busy, ser_valid}), 8'(3'b100));
        @(posedge clk);
        #1 req0_valid = 1'b0;
        grab(bits, lasts, valids, readys, gids);
        check("busy next bits", 8'(bits), 8'(4'b0011));
        check("busy next valid", 8'(valids), 8'(4'b1111));

        // Randomized traffic against a frame-position reference model.
        do_reset();
        m_busy = 1'b0; m_gid = 1'b0; m_last = 1'b1; m_pos = 0; m_word = '0;
        acc0 = 1'b0; acc1 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_valid = 1'b1; req0_data = W'($urandom);
            end else if (req0_valid && m_busy) begin
                req0_data = W'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_valid = 1'b1; req1_data = W'($urandom);
            end else if (req1_valid && m_busy) begin
                req1_data = W'($urandom);
            end
            ser_hold = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 99) != 0);
            #1;
            e_r0 = 1'b0; e_r1 = 1'b0; e_so = 1'b0; e_sl = 1'b0;
            if (!rst) begin
                exp = '0;
            end else begin
                if (req0_valid && req1_valid) g = (m_last == 1'b0);
                else                          g = req1_valid;
                e_r0 = !m_busy && req0_valid && !g;
                e_r1 = !m_busy && req1_valid && g;
                if (m_busy) begin
                    e_so = m_word[W-1-m_pos];
                    e_sl = (m_pos == W - 1);
                end
                exp = {e_r0, e_r1, e_so, m_busy, e_sl, m_gid, m_busy};
            end
            check($sformatf("random cyc%0d", n), 8'(outs()), 8'(exp));
            acc0 = e_r0; acc1 = e_r1;
            if (!rst) begin
                m_busy = 1'b0; m_pos = 0; m_gid = 1'b0; m_last = 1'b1;
            end else if (!m_busy) begin
                if (e_r0 || e_r1) begin
                    m_busy = 1'b1; m_pos = 0; m_gid = e_r1; m_last = e_r1;
                    m_word = e_r1 ? req1_data : req0_data;
                end
            end else if (!ser_hold) begin
                if (m_pos == W - 1) m_busy = 1'b0;
                else                m_pos++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_tx_arb.md
SHIFT_TX_ARB -- requirements
Module: shift_tx_arb

Interface
REQ-001 Parameter WIDTH, default 4, sets the parallel word width and the bits per serial frame (WIDTH >= 2).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; 0 forces reset state immediately, release is synchronous to clk.
REQ-004 req0_valid  input  1  requester 0 has a word to send.
REQ-005 req0_data  input  WIDTH  requester 0 parallel word, sampled on the accept edge.
REQ-006 req0_ready  output  1  requester 0 word accepted this cycle when req0_valid is also 1.
REQ-007 req1_valid  input  1  requester 1 has a word to send.
REQ-008 req1_data  input  WIDTH  requester 1 parallel word.
REQ-009 req1_ready  output  1  requester 1 acceptance strobe, same rule as req0_ready.
REQ-010 ser_hold  input  1  downstream stall; freezes shifting while 1.
REQ-011 ser_out  output  1  serial data bit, MSB first.
REQ-012 ser_valid  output  1  ser_out carries a frame bit this cycle.
REQ-013 ser_last  output  1  ser_out carries the final (LSB) bit of the frame.
REQ-014 grant_id  output  1  requester whose word is currently being shifted (0 or 1).
REQ-015 busy  output  1  a frame is in progress (state SHIFT).

Function
REQ-016 Two states: IDLE and SHIFT.
REQ-017 In IDLE, grant goes to the sole valid requester; with both valid, grant goes to the requester not served last (round-robin).
REQ-018 reqN_ready = (state==IDLE) && granted N && reqN_valid && rst==1; never both 1 in one cycle; 0 in SHIFT.
REQ-019 On an accept edge, the block loads reqN_data into a WIDTH-bit shift register, loads grant_id=N, records N as last served, clears the bit counter and moves to SHIFT.
REQ-020 In SHIFT: ser_valid=1, busy=1, ser_out = shift register MSB; ser_valid, ser_out and ser_last are registered outputs.
REQ-021 Each edge in SHIFT with ser_hold=0 shifts the register left by one (LSB fills 0) and increments the counter; with ser_hold=1 the register, counter, ser_out and ser_last hold.
REQ-022 ser_last = 1 exactly while the counter equals WIDTH-1.
REQ-023 An edge with ser_last=1 and ser_hold=0 returns to IDLE; ser_valid, ser_last and busy go 0 on that edge.
REQ-024 Latency: first bit on ser_out in the cycle after the accept edge; a frame occupies WIDTH unstalled cycles plus one IDLE arbitration cycle (back-to-back period WIDTH+1).
REQ-025 reqN_data and reqN_valid changes during SHIFT have no effect; requesters hold valid until ready.
REQ-026 grant_id holds its value in IDLE until the next accept.
REQ-027 The counter is ceil(log2(WIDTH)) bits minimum and does not wrap within a frame.

Reset
REQ-028 rst=0 forces: state IDLE, shift register 0, counter 0, ser_out 0, ser_valid 0, ser_last 0, busy 0, grant_id 0, both ready 0, last-served=1 (requester 0 wins the first tie).
REQ-029 rst=0 mid-frame aborts the frame immediately with no further ser_valid; after release the block arbitrates afresh from the REQ-028 state.

Verification
REQ-030 Single: req0_valid=1, req0_data=4'b1011 after reset -> req0_ready for 1 cycle; ser_out 1,0,1,1 on 4 consecutive cycles with ser_valid=1, ser_last only on 4th, grant_id=0.
REQ-031 Tie: both valid from reset, data0=4'b1111, data1=4'b0001 -> frame 1111 (grant 0), one IDLE cycle, then frame 0001 (grant 1), then 1111 again if both remain valid.
REQ-032 Stall: req1 sends 4'b1000, ser_hold=1 for 3 cycles on 2nd bit -> 2nd bit (0) held 4 cycles total, frame completes 1,0,0,0, ser_last once.
REQ-033 Mid-frame reset: req0 sends 4'b0101, rst=0 after 2 bits -> ser_valid/busy drop asynchronously; after release req0=4'b0011 yields frame 0,0,1,1.
REQ-034 Ignore-during-busy: change req0_data during SHIFT -> serialized frame matches word sampled at accept edge; no ready asserted during SHIFT.
